// File: rtl/token_burst_packer.sv
// token_burst_packer: gathers single-cycle token pulses into counted bursts
// and offers them on a valid/ready port. A burst goes out once BURST tokens
// are pending, or as a partial burst after TIMEOUT idle cycles. Tokens that
// arrive when the pending counter is full are lost, and this sets a sticky
// overflow flag.
module token_burst_packer #(
   parameter int BURST   = 4,
   parameter int PEND_W  = 4,
   parameter int TIMEOUT = 8,
   parameter int LEN_W   = $clog2(BURST + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LEN_W-1:0]  out_len,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   // The pending arithmetic uses one spare bit so that saturation can be
   // detected without wrapping.
   localparam logic [PEND_W:0]     MAX_PEND  = {1'b0, {PEND_W{1'b1}}};
   localparam logic [PEND_W:0]     BURST_EXT = (PEND_W + 1)'(BURST);
   localparam logic [IDLE_W-1:0]   TIMEOUT_C = IDLE_W'(TIMEOUT);
   localparam logic [LEN_W-1:0]    BURST_LEN = LEN_W'(BURST);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      OFFER
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [IDLE_W-1:0]   idle_cnt;
   logic [IDLE_W-1:0]   idle_next;
   logic [PEND_W-1:0]   pending_next;
   logic [PEND_W:0]     pend_sum;
   logic [LEN_W-1:0]    len_next;
   logic                overflow_next;
   logic                handshake;

   assign out_valid = (state == OFFER);
   assign handshake = out_valid & out_ready;

   // Pending count: add the incoming token and subtract an accepted burst in
   // the same cycle. A token that would push the count past its maximum is
   // dropped, and this raises overflow.
   always_comb begin
      pend_sum      = {1'b0, pending} + (PEND_W + 1)'(a)
                      - (handshake ? (PEND_W + 1)'(out_len) : '0);
      pending_next  = pend_sum[PEND_W-1:0];
      overflow_next = overflow;
      if (pend_sum > MAX_PEND) begin
         pending_next  = pending;
         overflow_next = 1'b1;
      end
   end

   // Idle counter: counts quiet cycles while tokens are waiting but no burst
   // is offered, and saturates at TIMEOUT.
   always_comb begin
      idle_next = idle_cnt;
      if (a || (pending == '0) || (state == OFFER)) begin
         idle_next = '0;
      end else if (idle_cnt != TIMEOUT_C) begin
         idle_next = idle_cnt + IDLE_W'(1);
      end
   end

   // Burst FSM: decides when to offer a burst and how long it is. After
   // each accepted beat it chains a full burst, falls back to FILL, or
   // falls back to IDLE.
   always_comb begin
      state_next = state;
      len_next   = out_len;
      case (state)
         IDLE, FILL: begin
            if ({1'b0, pending} >= BURST_EXT) begin
               state_next = OFFER;
               len_next   = BURST_LEN;
            end else if ((state == FILL) && (idle_cnt == TIMEOUT_C)) begin
               state_next = OFFER;
               len_next   = LEN_W'(pending);
            end else begin
               state_next = (pending_next == '0) ? IDLE : FILL;
               len_next   = '0;
            end
         end
         OFFER: begin
            if (handshake) begin
               if ({1'b0, pending_next} >= BURST_EXT) begin
                  state_next = OFFER;
                  len_next   = BURST_LEN;
               end else if (pending_next != '0) begin
                  state_next = FILL;
                  len_next   = '0;
               end else begin
                  state_next = IDLE;
                  len_next   = '0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            len_next   = '0;
         end
      endcase
   end

   // State register. Reset discards pending tokens and any offered burst at
   // once, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pending  <= '0;
         idle_cnt <= '0;
         out_len  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_next;
         pending  <= pending_next;
         idle_cnt <= idle_next;
         out_len  <= len_next;
         overflow <= overflow_next;
      end
   end

endmodule

// File: tb/tb_token_burst_packer.sv
// Testbench for token_burst_packer. A cycle-level integer model of the
// burst rules runs alongside the DUT and is compared against it every cycle.
// Directed scenarios are followed by a randomized doubler-chain run.
module tb_token_burst_packer;

   localparam int BURST   = 4;
   localparam int PEND_W  = 4;
   localparam int TIMEOUT = 8;
   localparam int LEN_W   = $clog2(BURST + 1);
   localparam int MAXP    = (1 << PEND_W) - 1;

   logic              clk;
   logic              rst;
   logic              a;
   logic              out_valid;
   logic              out_ready;
   logic [LEN_W-1:0]  out_len;
   logic [PEND_W-1:0] pending;
   logic              overflow;

   int checks   = 0;
   int failures = 0;

   int m_pending;
   int m_idle;
   int m_len;
   bit m_valid;
   bit m_ovf;

   int hs_count;
   int len_sum;
   int accepted;

   token_burst_packer #(
      .BURST(BURST),
      .PEND_W(PEND_W),
      .TIMEOUT(TIMEOUT),
      .LEN_W(LEN_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .a(a),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_len(out_len),
      .pending(pending),
      .overflow(overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_pending = 0;
      m_idle    = 0;
      m_len     = 0;
      m_valid   = 1'b0;
      m_ovf     = 1'b0;
      hs_count  = 0;
      len_sum   = 0;
      accepted  = 0;
   endtask

   // One clock edge of the burst rules, written with plain integers.
   task automatic modelStep(input bit ai, input bit ri);
      bit hs;
      bit nv;
      int np;
      int ni;
      int nlen;
      hs = m_valid && ri;
      np = m_pending + int'(ai) - (hs ? m_len : 0);
      if (np > MAXP) begin
         np    = MAXP;
         m_ovf = 1'b1;
      end else if (ai) begin
         accepted++;
      end
      if (ai || m_pending == 0 || m_valid) ni = 0;
      else ni = (m_idle < TIMEOUT) ? m_idle + 1 : TIMEOUT;
      nv   = m_valid;
      nlen = m_len;
      if (m_valid) begin
         if (hs) begin
            if (np >= BURST) nlen = BURST;
            else begin
               nv   = 1'b0;
               nlen = 0;
            end
         end
      end else if (m_pending >= BURST) begin
         nv   = 1'b1;
         nlen = BURST;
      end else if (m_pending > 0 && m_idle >= TIMEOUT) begin
         nv   = 1'b1;
         nlen = m_pending;
      end
      m_pending = np;
      m_idle    = ni;
      m_valid   = nv;
      m_len     = nlen;
   endtask

   task automatic checkAll(input string phase);
      checkOutput({phase, "_out_valid"}, 32'(out_valid), 32'(m_valid));
      checkOutput({phase, "_out_len"},   32'(out_len),   32'(m_len));
      checkOutput({phase, "_pending"},   32'(pending),   32'(m_pending));
      checkOutput({phase, "_overflow"},  32'(overflow),  32'(m_ovf));
   endtask

   task automatic applyStimulus(input bit ai, input bit ri, input string phase);
      a         = ai;
      out_ready = ri;
      if (out_valid && out_ready) begin
         hs_count++;
         len_sum += int'(out_len);
      end
      @(posedge clk);
      modelStep(ai, ri);
      #1;
      checkAll(phase);
   endtask

   task automatic doReset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a         = 1'($urandom);
         out_ready = 1'($urandom);
         @(posedge clk);
         #1;
         checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
         checkOutput("rst_out_len",   32'(out_len),   32'd0);
         checkOutput("rst_pending",   32'(pending),   32'd0);
         checkOutput("rst_overflow",  32'(overflow),  32'd0);
      end
      a         = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      modelReset();
   endtask

   initial begin
      int orig;
      int owed;
      bit ai;
      rst       = 1'b0;
      a         = 1'b0;
      out_ready = 1'b0;
      modelReset();

      // reset state, then quiet cycles
      doReset();
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'($urandom), "quiet");

      // full burst
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, "full");
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, "full");
      checkOutput("full_hs_count", 32'(hs_count), 32'd1);
      checkOutput("full_len_sum",  32'(len_sum),  32'd4);

      // timeout flush of a partial burst
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, "tmo");
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, "tmo");
      checkOutput("tmo_hs_count", 32'(hs_count), 32'd1);
      checkOutput("tmo_len_sum",  32'(len_sum),  32'd3);

      // backpressure, then back-to-back beats and a trailing flush
      doReset();
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, "bp");
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, "bp");
      checkOutput("bp_hs_count", 32'(hs_count), 32'd3);
      checkOutput("bp_len_sum",  32'(len_sum),  32'd9);

      // saturation and sticky overflow
      doReset();
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, "ovf");
      checkOutput("ovf_set", 32'(overflow), 32'd1);
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, "ovf");
      checkOutput("ovf_len_sum", 32'(len_sum), 32'd15);
      checkOutput("ovf_sticky",  32'(overflow), 32'd1);

      // random traffic interrupted by an asynchronous reset
      doReset();
      for (int i = 0; i < 40; i++)
         applyStimulus(1'($urandom_range(99) < 30), 1'($urandom_range(99) < 70), "pre");
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_out_valid", 32'(out_valid), 32'd0);
      checkOutput("async_out_len",   32'(out_len),   32'd0);
      checkOutput("async_pending",   32'(pending),   32'd0);
      checkOutput("async_overflow",  32'(overflow),  32'd0);
      a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      modelReset();

      // chain with an upstream doubler: each original token becomes two pulses
      orig = 0;
      owed = 0;
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(99) < 30) begin
            orig++;
            owed += 2;
         end
         ai = (owed > 0);
         if (ai) owed--;
         applyStimulus(ai, 1'($urandom_range(99) < 70), "chain");
      end
      for (int i = 0; i < 300; i++) begin
         ai = (owed > 0);
         if (ai) owed--;
         applyStimulus(ai, 1'($urandom_range(99) < 70), "drain");
      end
      checkOutput("chain_conserve", 32'(len_sum), 32'(accepted));
      if (!m_ovf) checkOutput("chain_doubled", 32'(len_sum), 32'(2 * orig));
      checkOutput("chain_pending_final", 32'(pending), 32'd0);
      checkOutput("chain_overflow", 32'(overflow), 32'(m_ovf));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
